stall_controller: RTL and testbench
===================================

Name: stall_controller

Overview:
- Generates the five stall_* inputs consumed by the core's multicycle phase sequencer.
- Watches the one-hot phase_* outputs and holds the sequencer in a phase while that phase's work is outstanding:
  - instruction-memory fetch handshake
  - multicycle execute
  - data-memory access handshake
- Includes a bus-timeout watchdog so a missing ack cannot hang the core.

Parameters:
- TIMEOUT_W, 8: width of the wait-cycle counter.
- TIMEOUT, 255: number of WAIT cycles without an ack before the timeout fires. Legal range 1 to 2^TIMEOUT_W-1.

Ports:
- clk  input  1  core clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- phase_fetch  input  1  sequencer in FETCH
- phase_decode  input  1  sequencer in DECODE
- phase_execute  input  1  sequencer in EXECUTE
- phase_memoryaccess  input  1  sequencer in MEMORYACCESS
- phase_writeback  input  1  sequencer in WRITEBACK
- imem_req  output  1  instruction fetch request, level, registered
- imem_ack  input  1  instruction memory completion
- dmem_access  input  1  current instruction is a load or store; valid during phase_memoryaccess
- dmem_req  output  1  data access request, level, registered
- dmem_ack  input  1  data memory completion
- exec_busy  input  1  multicycle ALU still busy
- stall_fetch  output  1  hold FETCH
- stall_decode  output  1  hold DECODE
- stall_execute  output  1  hold EXECUTE
- stall_memoryaccess  output  1  hold MEMORYACCESS
- stall_writeback  output  1  hold WRITEBACK
- bus_timeout  output  1  sticky error flag
- stall_cycles  output  32  stall-cycle count; see Optional Feature

Behaviour:
- Reset, asynchronous and taking effect immediately:
  - FSM goes to IDLE.
  - imem_req, dmem_req, bus_timeout are 0.
  - Counters are 0.
  - All stalls evaluate from IDLE: stall_fetch=phase_fetch, stall_memoryaccess=phase_memoryaccess&dmem_access.
- A single FSM with states IDLE, IF_WAIT, MA_WAIT, DONE serves both handshakes.
- FSM transitions:
  - IDLE with phase_fetch=1 -> IF_WAIT; imem_req goes 1 on the next cycle.
  - IDLE with phase_memoryaccess=1 and dmem_access=1 -> MA_WAIT; dmem_req goes 1 on the next cycle.
  - IDLE with phase_memoryaccess=1 and dmem_access=0 -> stays IDLE, no request.
  - IF_WAIT with imem_ack=1 -> DONE; imem_req goes 0.
  - MA_WAIT with dmem_ack=1 -> DONE; dmem_req goes 0.
  - DONE with the active phase input low -> IDLE.
- Ack sampling:
  - An ack is only honoured while the matching req is 1; an ack in any other state is ignored.
  - req and ack high in the same cycle completes the handshake in that cycle.
- Stall equations:
  - stall_fetch = phase_fetch & (state!=DONE)
  - stall_memoryaccess = phase_memoryaccess & dmem_access & (state!=DONE)
  - stall_execute = phase_execute & exec_busy, combinational, no FSM involvement
  - stall_decode = 0 and stall_writeback = 0 (constant)
- Latency: phase_fetch rises in cycle N and imem_req is 1 in N+1.
  - If ack comes in N+1, stall_fetch=0 in N+2 and the sequencer leaves FETCH at the N+2 edge.
  - Minimum FETCH residency is therefore 3 cycles.
  - Memory access has the same timing.
- Timeout:
  - The wait counter clears on entry to IF_WAIT or MA_WAIT and increments each WAIT cycle without an ack.
  - When it reaches TIMEOUT: bus_timeout is set (sticky until rst), the FSM goes to DONE, and req drops, releasing the stall.
  - An ack arriving in the same cycle as the timeout wins; bus_timeout is not set.
- No phase asserted (sequencer INITIAL): all stalls 0, FSM stays IDLE.
- Phase input dropping while in a WAIT state is not a legal sequencer behaviour. The block has no recovery for it other than rst.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined: stall_cycles is a 32-bit counter.
  - Increments each cycle in which any stall_* output is 1.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by rst.
- Undefined: the counter is not built and stall_cycles is tied to 0.

Test Plan:
- Fetch with ack 2 cycles after req:
  - phase_fetch rises in cycle 0; imem_req=1 in cycles 1-2; imem_ack=1 in cycle 2.
  - Required: stall_fetch=1 in cycles 0-2 and 0 in cycle 3; imem_req=0 in cycle 3.
- Memory phase with dmem_access=0:
  - Required: stall_memoryaccess=0 throughout and dmem_req never asserted.
- Memory phase with dmem_access=1 and ack in the same cycle as req:
  - Required: 3-cycle residency; dmem_req high for exactly 1 cycle.
- exec_busy high for 4 cycles during phase_execute:
  - Required: stall_execute=1 for exactly those 4 cycles.
- Timeout with TIMEOUT=4 and no imem_ack:
  - Required: bus_timeout=1 after 4 WAIT cycles; stall_fetch releases; bus_timeout stays 1 until rst pulses.
  - Variant: ack in the terminal WAIT cycle leaves bus_timeout=0.
- Reset mid-handshake:
  - Assert rst while imem_req=1.
  - Required: imem_req=0 with no clock edge; FSM IDLE; stall_cycles=0 when STALL_PERF_CNT_EN is defined.

Source files
------------

// File: rtl/stall_controller.sv
// Stall generator for the multicycle phase sequencer: fetch/data handshakes, execute hold, bus-timeout watchdog.
// Optional stall-cycle performance counter is built when STALL_PERF_CNT_EN is defined.
module stall_controller #(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        phase_fetch,
    input  logic        phase_decode,
    input  logic        phase_execute,
    input  logic        phase_memoryaccess,
    input  logic        phase_writeback,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic        dmem_access,
    output logic        dmem_req,
    input  logic        dmem_ack,
    input  logic        exec_busy,
    output logic        stall_fetch,
    output logic        stall_decode,
    output logic        stall_execute,
    output logic        stall_memoryaccess,
    output logic        stall_writeback,
    output logic        bus_timeout,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_WAIT = 2'd1,
        ST_MA_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Last counter value seen in a WAIT cycle before the watchdog fires.
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] CNT_ONE      = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] CNT_ZERO     = TIMEOUT_W'(0);

    state_t                 state_r;
    state_t                 state_s;
    logic [TIMEOUT_W-1:0]   wait_cnt_r;
    logic [TIMEOUT_W-1:0]   wait_cnt_s;
    logic                   imem_req_r;
    logic                   dmem_req_r;
    logic                   bus_timeout_r;
    logic                   timeout_set_s;
    logic                   phase_any_s;
    logic                   imem_done_s;
    logic                   dmem_done_s;

    assign phase_any_s = phase_fetch | phase_decode | phase_execute
                       | phase_memoryaccess | phase_writeback;
    assign imem_done_s = imem_req_r & imem_ack;
    assign dmem_done_s = dmem_req_r & dmem_ack;

    // Next-state and watchdog counter logic.
    always_comb begin
        state_s       = state_r;
        wait_cnt_s    = wait_cnt_r;
        timeout_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                wait_cnt_s = CNT_ZERO;
                if (!phase_any_s) begin
                    state_s = ST_IDLE;
                end else if (phase_fetch) begin
                    state_s = ST_IF_WAIT;
                end else if (phase_memoryaccess && dmem_access) begin
                    state_s = ST_MA_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_IF_WAIT: begin
                if (imem_done_s) begin
                    state_s = ST_DONE;
                end else if (wait_cnt_r == TIMEOUT_LAST) begin
                    state_s       = ST_DONE;
                    timeout_set_s = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + CNT_ONE;
                end
            end
            ST_MA_WAIT: begin
                if (dmem_done_s) begin
                    state_s = ST_DONE;
                end else if (wait_cnt_r == TIMEOUT_LAST) begin
                    state_s       = ST_DONE;
                    timeout_set_s = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + CNT_ONE;
                end
            end
            ST_DONE: begin
                // Hold until the sequencer has left the phase that owned the handshake.
                if (phase_fetch || phase_memoryaccess) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, request and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            wait_cnt_r    <= CNT_ZERO;
            imem_req_r    <= 1'b0;
            dmem_req_r    <= 1'b0;
            bus_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            wait_cnt_r    <= wait_cnt_s;
            imem_req_r    <= (state_s == ST_IF_WAIT);
            dmem_req_r    <= (state_s == ST_MA_WAIT);
            bus_timeout_r <= bus_timeout_r | timeout_set_s;
        end
    end

    assign imem_req           = imem_req_r;
    assign dmem_req           = dmem_req_r;
    assign bus_timeout        = bus_timeout_r;
    assign stall_fetch        = phase_fetch & (state_r != ST_DONE);
    assign stall_memoryaccess = phase_memoryaccess & dmem_access & (state_r != ST_DONE);
    assign stall_execute      = phase_execute & exec_busy;
    assign stall_decode       = 1'b0;
    assign stall_writeback    = 1'b0;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles_r;
    logic        any_stall_s;

    assign any_stall_s = stall_fetch | stall_decode | stall_execute
                       | stall_memoryaccess | stall_writeback;

    // Free-running stall-cycle counter; wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_r <= 32'd0;
        end else if (any_stall_s) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall_cycles = stall_cycles_r;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_stall_controller.sv
// Scoreboard bench for stall_controller with TIMEOUT=4; per-cycle expectations are queued then compared.
module tb_stall_controller;

    logic        clk;
    logic        rst;
    logic        phase_fetch, phase_decode, phase_execute, phase_memoryaccess, phase_writeback;
    logic        imem_req, imem_ack, dmem_access, dmem_req, dmem_ack, exec_busy;
    logic        stall_fetch, stall_decode, stall_execute, stall_memoryaccess, stall_writeback;
    logic        bus_timeout;
    logic [31:0] stall_cycles;

    logic [7:0]  obs_s;
    logic [7:0]  exp_q [$];
    logic [7:0]  exp_v;
    int          checks;
    int          errors;
    logic [31:0] exp_perf;

    stall_controller #(.TIMEOUT_W(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .phase_fetch(phase_fetch), .phase_decode(phase_decode), .phase_execute(phase_execute),
        .phase_memoryaccess(phase_memoryaccess), .phase_writeback(phase_writeback),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_access(dmem_access), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .exec_busy(exec_busy),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_execute(stall_execute),
        .stall_memoryaccess(stall_memoryaccess), .stall_writeback(stall_writeback),
        .bus_timeout(bus_timeout), .stall_cycles(stall_cycles)
    );

    // Observed vector: {sf, sd, se, sm, sw, imem_req, dmem_req, bus_timeout}
    assign obs_s = {stall_fetch, stall_decode, stall_execute, stall_memoryaccess,
                    stall_writeback, imem_req, dmem_req, bus_timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input vector: {pf, pd, pe, pm, pw, imem_ack, dmem_access, dmem_ack, exec_busy}
    task automatic drive(input logic [8:0] v);
        {phase_fetch, phase_decode, phase_execute, phase_memoryaccess, phase_writeback,
         imem_ack, dmem_access, dmem_ack, exec_busy} = v;
    endtask

    task automatic test_reset();
        logic [8:0] ins  [3];
        logic [7:0] exps [3];
        ins  = '{9'b000000000, 9'b100000000, 9'b000100100};
        exps = '{8'h00, 8'h80, 8'h10};
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(ins[i]);
            exp_q.push_back(exps[i]);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_s !== exp_v) begin
                errors++;
                $display("FAIL reset step %0d: got %b expected %b", i, obs_s, exp_v);
            end
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d expected 0", stall_cycles);
        end
        drive(9'b000000000);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        logic [8:0] ins  [5];
        logic [7:0] exps [5];
        ins  = '{9'b100001000, 9'b100000000, 9'b100001000, 9'b100000000, 9'b010000000};
        exps = '{8'h80, 8'h84, 8'h84, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive(ins[i]);
            exp_q.push_back(exps[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_s !== exp_v) begin
                errors++;
                $display("FAIL fetch cycle %0d: got %b expected %b", i, obs_s, exp_v);
            end
        end
`ifdef STALL_PERF_CNT_EN
        exp_perf = 32'd3;
`else
        exp_perf = 32'd0;
`endif
        checks++;
        if (stall_cycles !== exp_perf) begin
            errors++;
            $display("FAIL fetch_perf: got %0d expected %0d", stall_cycles, exp_perf);
        end
    endtask

    task automatic test_mem_noaccess();
        logic [8:0] ins  [3];
        logic [7:0] exps [3];
        ins  = '{9'b000100000, 9'b000100010, 9'b000010000};
        exps = '{8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(ins[i]);
            exp_q.push_back(exps[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_s !== exp_v) begin
                errors++;
                $display("FAIL mem_noaccess cycle %0d: got %b expected %b", i, obs_s, exp_v);
            end
        end
    endtask

    task automatic test_mem_same_cycle();
        logic [8:0] ins  [4];
        logic [7:0] exps [4];
        ins  = '{9'b000100110, 9'b000100110, 9'b000100100, 9'b000010000};
        exps = '{8'h10, 8'h12, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive(ins[i]);
            exp_q.push_back(exps[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_s !== exp_v) begin
                errors++;
                $display("FAIL mem_same_cycle cycle %0d: got %b expected %b", i, obs_s, exp_v);
            end
        end
    endtask

    task automatic test_exec();
        logic [8:0] ins  [7];
        logic [7:0] exps [7];
        ins  = '{9'b001000000, 9'b001000001, 9'b001000001, 9'b001000001,
                 9'b001000001, 9'b001000000, 9'b000100001};
        exps = '{8'h00, 8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            drive(ins[i]);
            exp_q.push_back(exps[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_s !== exp_v) begin
                errors++;
                $display("FAIL exec cycle %0d: got %b expected %b", i, obs_s, exp_v);
            end
        end
    endtask

    task automatic test_timeout_ack_wins();
        logic [8:0] ins  [7];
        logic [7:0] exps [7];
        ins  = '{9'b100000000, 9'b100000000, 9'b100000000, 9'b100000000,
                 9'b100001000, 9'b100000000, 9'b010000000};
        exps = '{8'h80, 8'h84, 8'h84, 8'h84, 8'h84, 8'h00, 8'h00};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            drive(ins[i]);
            exp_q.push_back(exps[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_s !== exp_v) begin
                errors++;
                $display("FAIL timeout_ack_wins cycle %0d: got %b expected %b", i, obs_s, exp_v);
            end
        end
    endtask

    task automatic test_timeout();
        logic [8:0] ins  [8];
        logic [7:0] exps [8];
        ins  = '{9'b100000000, 9'b100000000, 9'b100000000, 9'b100000000,
                 9'b100000000, 9'b100000000, 9'b010000000, 9'b000000000};
        exps = '{8'h80, 8'h84, 8'h84, 8'h84, 8'h84, 8'h01, 8'h01, 8'h01};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            drive(ins[i]);
            exp_q.push_back(exps[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_s !== exp_v) begin
                errors++;
                $display("FAIL timeout cycle %0d: got %b expected %b", i, obs_s, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_handshake();
        logic [8:0] ins  [2];
        logic [7:0] exps [2];
        ins  = '{9'b100000000, 9'b100000000};
        exps = '{8'h81, 8'h85};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            drive(ins[i]);
            exp_q.push_back(exps[i]);
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs_s !== exp_v) begin
                errors++;
                $display("FAIL reset_mid pre cycle %0d: got %b expected %b", i, obs_s, exp_v);
            end
        end
        // Reset lands between edges; outputs must clear before any clock.
        rst = 1'b1;
        exp_q.push_back(8'h80);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_s !== exp_v) begin
            errors++;
            $display("FAIL reset_mid async: got %b expected %b", obs_s, exp_v);
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_perf: got %0d expected 0", stall_cycles);
        end
        @(posedge clk); #1;
        drive(9'b000000000);
        rst = 1'b0;
        @(posedge clk); #1;
        drive(9'b100000000);
        exp_q.push_back(8'h80);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_s !== exp_v) begin
            errors++;
            $display("FAIL reset_mid post: got %b expected %b", obs_s, exp_v);
        end
        @(posedge clk); #1;
        exp_q.push_back(8'h84);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        checks++;
        if (obs_s !== exp_v) begin
            errors++;
            $display("FAIL reset_mid restart: got %b expected %b", obs_s, exp_v);
        end
    endtask

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(9'b000000000);
        test_reset();
        test_fetch();
        test_mem_noaccess();
        test_mem_same_cycle();
        test_exec();
        test_timeout_ack_wins();
        test_timeout();
        test_reset_mid_handshake();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
